// File: rtl/hack_pkg.sv
// hack_pkg: shared state encoding and instruction field positions for the Hack controller
package hack_pkg;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
   localparam int C_BIT   = 15;
   localparam int A_BIT   = 12;
   localparam int COMP_HI = 11;
   localparam int COMP_LO = 6;
   localparam int DEST_A  = 5;
   localparam int DEST_D  = 4;
   localparam int DEST_M  = 3;
   localparam int JUMP_HI = 2;
endpackage

// File: rtl/hack_jump_eval.sv
// hack_jump_eval: jump-taken decision from the three jump bits and registered {ng,zr}
module hack_jump_eval (
   input  logic [2:0] i_jump,
   input  logic       i_ng,
   input  logic       i_zr,
   output logic       o_taken
);
   assign o_taken = (i_jump[2] & i_ng) | (i_jump[1] & i_zr) | (i_jump[0] & ~i_ng & ~i_zr);
endmodule

// File: rtl/hack_ctrl_fsm.sv
// hack_ctrl_fsm: fetch/decode/execute/writeback controller for the Hack CPU datapath,
// with ROM/RAM handshake stalls and a timeout that halts the core.
module hack_ctrl_fsm
   import hack_pkg::*;
#(
   parameter int IW      = 16,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [IW-1:0] instr,
   input  logic          instr_valid,
   input  logic          alu_zr,
   input  logic          alu_ng,
   input  logic          mem_ready,
   output logic          fetch_req,
   output logic          zx,
   output logic          nx,
   output logic          zy,
   output logic          ny,
   output logic          f,
   output logic          no,
   output logic          am_sel,
   output logic          a_sel_instr,
   output logic          load_a,
   output logic          load_d,
   output logic          mem_rd,
   output logic          write_m,
   output logic          pc_load,
   output logic          pc_inc,
   output logic          halted
);
   state_t        r_state, w_next;
   logic [IW-1:0] r_ir;
   logic [1:0]    r_flags;
   logic [7:0]    r_cnt;
   logic          w_c, w_commit, w_taken, w_alu_en, w_wait, w_unused;

   assign w_c      = r_ir[C_BIT];
   assign w_unused = ^r_ir[14:13];
   // A C-instr that writes memory commits only in the cycle RAM accepts the write
   assign w_commit = (r_state == S_WB) && (!w_c || !r_ir[DEST_M] || mem_ready);

   hack_jump_eval u_jump (
      .i_jump  (r_ir[JUMP_HI:0]),
      .i_ng    (r_flags[1]),
      .i_zr    (r_flags[0]),
      .o_taken (w_taken)
   );

   always_comb begin
      w_next      = r_state;
      fetch_req   = 1'b0;
      mem_rd      = 1'b0;
      write_m     = 1'b0;
      a_sel_instr = 1'b0;
      halted      = 1'b0;
      w_alu_en    = 1'b0;
      w_wait      = 1'b0;
      unique case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH: begin
            fetch_req = 1'b1;
            w_wait    = !instr_valid;
            w_next    = instr_valid ? S_DECODE : S_FETCH;
         end
         S_DECODE: w_next = w_c ? S_EXEC : S_WB;
         S_EXEC: begin
            w_alu_en = 1'b1;
            mem_rd   = r_ir[A_BIT];
            w_wait   = r_ir[A_BIT] && !mem_ready;
            w_next   = w_wait ? S_EXEC : S_WB;
         end
         S_WB: begin
            w_alu_en    = w_c;
            a_sel_instr = !w_c;
            write_m     = w_c && r_ir[DEST_M];
            w_wait      = !w_commit;
            w_next      = w_commit ? S_FETCH : S_WB;
         end
         S_HALT:   halted = 1'b1;
         default:  w_next = S_IDLE;
      endcase
      if (w_wait && r_cnt == 8'(TIMEOUT - 1)) w_next = S_HALT;
   end

   assign {zx, nx, zy, ny, f, no} = w_alu_en ? r_ir[COMP_HI:COMP_LO] : 6'd0;
   assign am_sel  = w_alu_en && r_ir[A_BIT];
   assign load_a  = w_commit && (!w_c || r_ir[DEST_A]);
   assign load_d  = w_commit && w_c && r_ir[DEST_D];
   assign pc_load = w_commit && w_c && w_taken;
   assign pc_inc  = w_commit && !(w_c && w_taken);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ir    <= '0;
         r_flags <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
         if (r_state == S_FETCH && instr_valid) r_ir <= instr;
         if (r_state == S_EXEC && w_next == S_WB) r_flags <= {alu_ng, alu_zr};
      end
   end
endmodule

// File: tb/tb_hack_ctrl_fsm.sv
// tb_hack_ctrl_fsm: directed per-cycle vectors; the driver queues expected outputs,
// a negedge monitor pops and compares them.
module tb_hack_ctrl_fsm;
   localparam logic [15:0] FR  = 16'h8000;
   localparam logic [15:0] AM  = 16'h0100;
   localparam logic [15:0] ASI = 16'h0080;
   localparam logic [15:0] LA  = 16'h0040;
   localparam logic [15:0] LD  = 16'h0020;
   localparam logic [15:0] RD  = 16'h0010;
   localparam logic [15:0] WM  = 16'h0008;
   localparam logic [15:0] PL  = 16'h0004;
   localparam logic [15:0] PI  = 16'h0002;
   localparam logic [15:0] H   = 16'h0001;

   typedef struct {
      logic [15:0] exp;
      string       name;
   } item_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid, alu_zr, alu_ng, mem_ready;
   logic        fetch_req, zx, nx, zy, ny, f, no, am_sel, a_sel_instr;
   logic        load_a, load_d, mem_rd, write_m, pc_load, pc_inc, halted;
   logic [15:0] w_out;
   item_t       q[$];
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   hack_ctrl_fsm #(.IW(16), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .alu_zr(alu_zr), .alu_ng(alu_ng), .mem_ready(mem_ready),
      .fetch_req(fetch_req), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
      .am_sel(am_sel), .a_sel_instr(a_sel_instr), .load_a(load_a), .load_d(load_d),
      .mem_rd(mem_rd), .write_m(write_m), .pc_load(pc_load), .pc_inc(pc_inc),
      .halted(halted)
   );

   assign w_out = {fetch_req, zx, nx, zy, ny, f, no, am_sel, a_sel_instr,
                   load_a, load_d, mem_rd, write_m, pc_load, pc_inc, halted};

   function automatic logic [15:0] alu(input logic [5:0] a);
      return {1'b0, a, 9'd0};
   endfunction

   always @(negedge clk) begin
      if (q.size() > 0) begin
         item_t it;
         it = q.pop_front();
         n_checks++;
         if (w_out !== it.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", it.name, w_out, it.exp);
         end
      end
   end

   task automatic cyc(input logic rst, input logic iv, input logic [15:0] ins,
                      input logic mr, input logic ng, input logic zr,
                      input logic [15:0] exp, input string nm);
      reset       = rst;
      instr_valid = iv;
      instr       = ins;
      mem_ready   = mr;
      alu_ng      = ng;
      alu_zr      = zr;
      q.push_back('{exp, nm});
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b1; instr = 16'h0005;
      mem_ready = 1'b0; alu_ng = 1'b0; alu_zr = 1'b0;
      @(posedge clk);
      #1;
      cyc(0, 1, 16'h0005, 0, 0, 0, 16'h0, "rst_idle");
      cyc(0, 1, 16'h0005, 0, 0, 0, FR, "fetch_a");
      cyc(0, 0, 16'h0000, 0, 0, 0, 16'h0, "dec_a");
      cyc(0, 0, 16'h0000, 0, 0, 0, ASI | LA | PI, "wb_a");
      // D=M+1 with a 3-cycle read stall
      cyc(0, 1, 16'hFDD0, 1, 0, 0, FR, "fetch_dm1");
      cyc(0, 0, 16'h0000, 0, 0, 0, 16'h0, "dec_dm1");
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 16'h0000, 0, 0, 0, alu(6'b110111) | AM | RD, "exec_rd_wait");
      cyc(0, 0, 16'h0000, 1, 0, 0, alu(6'b110111) | AM | RD, "exec_rd_done");
      cyc(0, 0, 16'h0000, 0, 0, 0, alu(6'b110111) | AM | LD | PI, "wb_dm1");
      // D;JGT with positive D, stray instr_valid in DECODE must not reload IR
      cyc(0, 1, 16'hE301, 0, 0, 0, FR, "fetch_jgt");
      cyc(0, 1, 16'hFFFF, 0, 0, 0, 16'h0, "dec_jgt_stray");
      cyc(0, 0, 16'h0000, 0, 0, 0, alu(6'b001100), "exec_jgt");
      cyc(0, 0, 16'h0000, 0, 0, 0, alu(6'b001100) | PL, "wb_jgt_taken");
      // D;JGT with zero D
      cyc(0, 1, 16'hE301, 0, 0, 0, FR, "fetch_jgt2");
      cyc(0, 0, 16'h0000, 0, 0, 0, 16'h0, "dec_jgt2");
      cyc(0, 0, 16'h0000, 0, 0, 1, alu(6'b001100), "exec_jgt2");
      cyc(0, 0, 16'h0000, 0, 0, 0, alu(6'b001100) | PI, "wb_jgt_not");
      // 0;JMP
      cyc(0, 1, 16'hEA87, 0, 0, 0, FR, "fetch_jmp");
      cyc(0, 0, 16'h0000, 0, 0, 0, 16'h0, "dec_jmp");
      cyc(0, 0, 16'h0000, 0, 1, 0, alu(6'b101010), "exec_jmp");
      cyc(0, 0, 16'h0000, 0, 0, 0, alu(6'b101010) | PL, "wb_jmp");
      // M=D with write accepted after 2 waits
      cyc(0, 1, 16'hE308, 0, 0, 0, FR, "fetch_md");
      cyc(0, 0, 16'h0000, 0, 0, 0, 16'h0, "dec_md");
      cyc(0, 0, 16'h0000, 1, 0, 0, alu(6'b001100), "exec_md");
      cyc(0, 0, 16'h0000, 0, 0, 0, alu(6'b001100) | WM, "wb_md_wait1");
      cyc(0, 0, 16'h0000, 0, 0, 0, alu(6'b001100) | WM, "wb_md_wait2");
      cyc(0, 0, 16'h0000, 1, 0, 0, alu(6'b001100) | WM | PI, "wb_md_commit");
      // fetch timeout, stray mem_ready ignored
      for (int i = 0; i < 15; i++)
         cyc(0, 0, 16'h0000, 1, 0, 0, FR, "fetch_starve");
      cyc(0, 0, 16'h0000, 0, 0, 0, H, "halted");
      cyc(0, 1, 16'h0005, 1, 0, 0, H, "halt_sticky");
      cyc(1, 0, 16'h0000, 0, 0, 0, H, "halt_in_reset");
      cyc(0, 0, 16'h0000, 0, 0, 0, 16'h0, "rst_from_halt");
      // reset during a read stall
      cyc(0, 1, 16'hFDD0, 0, 0, 0, FR, "fetch_dm1b");
      cyc(0, 0, 16'h0000, 0, 0, 0, 16'h0, "dec_dm1b");
      cyc(0, 0, 16'h0000, 0, 0, 0, alu(6'b110111) | AM | RD, "exec_stall");
      cyc(1, 0, 16'h0000, 0, 0, 0, alu(6'b110111) | AM | RD, "exec_in_reset");
      cyc(0, 0, 16'h0000, 1, 0, 0, 16'h0, "rst_from_exec");
      cyc(0, 0, 16'h0000, 0, 0, 0, FR, "fetch_after_rst");
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
